// File: rtl/gray_to_binary_tracker_if.sv
// Bundles the sample-in and the decoded/flag-out signals of the Gray tracker.
// The master side feeds samples; the slave side is the tracker itself.
interface gray_to_binary_tracker_if #(
    parameter int unsigned W     = 4,
    parameter int unsigned ERR_W = 8
);
    logic             in_valid;
    logic [W-1:0]     g;
    logic             clr_err;
    logic             out_valid;
    logic [W-1:0]     b;
    logic             step_ok;
    logic             step_dir;
    logic             wrap;
    logic             repeat_hit;
    logic             step_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, g, clr_err,
        input  out_valid, b, step_ok, step_dir, wrap, repeat_hit, step_err, err_count
    );

    modport slave (
        input  in_valid, g, clr_err,
        output out_valid, b, step_ok, step_dir, wrap, repeat_hit, step_err, err_count
    );
endinterface

// File: rtl/gray_to_binary_tracker.sv
// Decodes a stream of Gray-coded samples to binary, classifies each step
// against the previous sample (repeat, +/-1, illegal) and keeps a saturating
// count of illegal steps. All outputs are registered; latency is one clock.
module gray_to_binary_tracker #(
    parameter int unsigned W     = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    gray_to_binary_tracker_if.slave  bus
);

    typedef enum logic [0:0] {StUnprimed, StTrack} state_e;

    state_e           state_q;
    logic [W-1:0]     prev_q;
    logic [W-1:0]     bin;
    logic [W-1:0]     d;
    logic             is_repeat;
    logic             is_up;
    logic             is_down;
    logic             step_illegal;

    logic             out_valid_q;
    logic [W-1:0]     b_q;
    logic             step_ok_q;
    logic             step_dir_q;
    logic             wrap_q;
    logic             repeat_hit_q;
    logic             step_err_q;
    logic [ERR_W-1:0] err_count_q;

    // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < int'(W); i++) begin
            bin[i] = ^(bus.g >> i);
        end
    end

    // Step classification against the last accepted sample (mod 2^W distance).
    always_comb begin
        d            = bin - prev_q;
        is_repeat    = (d == '0);
        // Up is tested first so that with W=1 a distance of 1 counts as up.
        is_up        = (d == W'(1));
        is_down      = !is_up && (d == '1);
        step_illegal = bus.in_valid && (state_q == StTrack) &&
                       !is_repeat && !is_up && !is_down;
    end

    // Tracker state machine with registered outputs and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StUnprimed;
            prev_q       <= '0;
            out_valid_q  <= 1'b0;
            b_q          <= '0;
            step_ok_q    <= 1'b0;
            step_dir_q   <= 1'b0;
            wrap_q       <= 1'b0;
            repeat_hit_q <= 1'b0;
            step_err_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            out_valid_q  <= bus.in_valid;
            step_ok_q    <= 1'b0;
            wrap_q       <= 1'b0;
            repeat_hit_q <= 1'b0;
            step_err_q   <= 1'b0;

            if (bus.in_valid) begin
                b_q     <= bin;
                prev_q  <= bin;
                state_q <= StTrack;
                if (state_q == StTrack) begin
                    if (is_repeat) begin
                        repeat_hit_q <= 1'b1;
                    end else if (is_up) begin
                        step_ok_q  <= 1'b1;
                        step_dir_q <= 1'b1;
                        wrap_q     <= (prev_q == '1);
                    end else if (is_down) begin
                        step_ok_q  <= 1'b1;
                        step_dir_q <= 1'b0;
                        wrap_q     <= (prev_q == '0);
                    end else begin
                        step_err_q <= 1'b1;
                    end
                end
            end

            // A clear in the same cycle as an illegal step leaves a count of one.
            if (bus.clr_err) begin
                err_count_q <= step_illegal ? ERR_W'(1) : '0;
            end else if (step_illegal && (err_count_q != '1)) begin
                err_count_q <= err_count_q + ERR_W'(1);
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.b          = b_q;
    assign bus.step_ok    = step_ok_q;
    assign bus.step_dir   = step_dir_q;
    assign bus.wrap       = wrap_q;
    assign bus.repeat_hit = repeat_hit_q;
    assign bus.step_err   = step_err_q;
    assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Self-checking bench for gray_to_binary_tracker (W=4, ERR_W=8): directed
// scenarios plus a randomized stream, compared against an integer model.
module tb_gray_to_binary_tracker;

    logic clk;
    logic rst;

    gray_to_binary_tracker_if #(.W(4), .ERR_W(8)) bus ();

    gray_to_binary_tracker #(.W(4), .ERR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    // Reference model state, kept as plain integers.
    bit m_primed;
    int m_prev;
    int m_b;
    bit m_dir;
    int m_err;
    bit e_valid, e_ok, e_wrap, e_rep, e_err;

    function automatic logic [3:0] gray(input int x);
        int v;
        v = x % 16;
        return 4'(v ^ (v >> 1));
    endfunction

    // Inverse Gray by search over all codes.
    function automatic int ungray(input logic [3:0] gv);
        for (int v = 0; v < 16; v++) begin
            if (gray(v) == gv) return v;
        end
        return -1;
    endfunction

    function automatic logic [17:0] exp_vec();
        logic [3:0] bb;
        logic [7:0] ee;
        bb = 4'(m_b);
        ee = 8'(m_err);
        return {e_valid, bb, e_ok, m_dir, e_wrap, e_rep, e_err, ee};
    endfunction

    function automatic logic [17:0] obs_vec();
        return {bus.out_valid, bus.b, bus.step_ok, bus.step_dir, bus.wrap,
                bus.repeat_hit, bus.step_err, bus.err_count};
    endfunction

    // Drive one cycle of stimulus and advance the model; sampling is #1 after the edge.
    task automatic apply(input bit v, input logic [3:0] gv, input bit clr);
        int val;
        int dd;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = v;
        bus.g        = gv;
        bus.clr_err  = clr;
        @(posedge clk);
        #1;
        e_valid = v;
        e_ok = 0; e_wrap = 0; e_rep = 0; e_err = 0;
        if (v) begin
            val = ungray(gv);
            if (m_primed) begin
                dd = (val - m_prev + 16) % 16;
                if (dd == 0) e_rep = 1;
                else if (dd == 1) begin e_ok = 1; m_dir = 1; e_wrap = (m_prev == 15); end
                else if (dd == 15) begin e_ok = 1; m_dir = 0; e_wrap = (m_prev == 0); end
                else e_err = 1;
            end
            m_prev   = val;
            m_b      = val;
            m_primed = 1;
        end
        if (clr) m_err = e_err ? 1 : 0;
        else if (e_err && m_err < 255) m_err++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'($urandom);
        bus.g        = 4'($urandom);
        bus.clr_err  = 1'($urandom);
        @(posedge clk);
        #1;
        m_primed = 0; m_prev = 0; m_b = 0; m_dir = 0; m_err = 0;
        e_valid = 0; e_ok = 0; e_wrap = 0; e_rep = 0; e_err = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (obs_vec() !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", obs_vec(), 18'h0);
        end
    endtask

    task automatic test_up_count();
        for (int i = 0; i <= 16; i++) begin
            apply(1'b1, gray(i), 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL up_step_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        // Final 15 -> 0 step must be a legal upward wrap.
        n_cmp++;
        if ({bus.step_ok, bus.step_dir, bus.wrap, bus.b} !== {3'b111, 4'd0}) begin
            n_fail++;
            $display("FAIL up_wrap: got %b want %b",
                     {bus.step_ok, bus.step_dir, bus.wrap, bus.b}, 7'b1110000);
        end
    endtask

    task automatic test_down_count();
        int seq [4] = '{2, 1, 0, 15};
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, gray(seq[i]), 1'b0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL down_step_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if ({bus.step_ok, bus.step_dir, bus.wrap} !== 3'b101) begin
            n_fail++;
            $display("FAIL down_wrap: got %b want %b",
                     {bus.step_ok, bus.step_dir, bus.wrap}, 3'b101);
        end
    endtask

    task automatic test_repeat_idle();
        apply(1'b1, gray(5), 1'b0);
        apply(1'b0, gray(9), 1'b0);
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.b !== 4'd5) begin
            n_fail++;
            $display("FAIL idle_hold: got %h want %h", obs_vec(), exp_vec());
        end
        apply(1'b1, gray(5), 1'b0);
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.repeat_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_illegal_resync();
        logic [7:0] err_before;
        apply(1'b1, gray(0), 1'b0);
        err_before = 8'(m_err);
        apply(1'b1, 4'b0010, 1'b0);
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.step_err !== 1'b1 ||
            bus.err_count !== err_before + 8'd1) begin
            n_fail++;
            $display("FAIL illegal_step: got %h want %h", obs_vec(), exp_vec());
        end
        apply(1'b1, gray(4), 1'b0);
        n_cmp++;
        if (obs_vec() !== exp_vec() || {bus.step_ok, bus.step_dir} !== 2'b11) begin
            n_fail++;
            $display("FAIL resync_step: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            apply(1'b1, gray(m_prev + 8), 1'b0);
            if (i % 50 == 0 || i == 299) begin
                n_cmp++;
                if (obs_vec() !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL sat_step_%0d: got %h want %h", i, obs_vec(), exp_vec());
                end
            end
        end
        n_cmp++;
        if (bus.err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL err_saturated: got %0d want 255", bus.err_count);
        end
        apply(1'b1, gray(m_prev + 8), 1'b1);
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL clr_with_err: got %h want %h", obs_vec(), exp_vec());
        end
        apply(1'b0, 4'd0, 1'b1);
        n_cmp++;
        if (obs_vec() !== exp_vec() || bus.err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_alone: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 3; i < 8; i++) apply(1'b1, gray(i), 1'b0);
        apply(1'b1, gray(m_prev + 5), 1'b0);
        do_reset();
        n_cmp++;
        if (obs_vec() !== 18'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got %h want %h", obs_vec(), 18'h0);
        end
        apply(1'b1, gray(11), 1'b0);
        n_cmp++;
        if (obs_vec() !== exp_vec() ||
            {bus.step_ok, bus.wrap, bus.repeat_hit, bus.step_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL first_after_reset: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int kind;
        bit clr;
        logic [3:0] gv;
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 4);
            clr  = ($urandom_range(0, 15) == 0);
            case (kind)
                1:       gv = gray(m_prev + 1);
                2:       gv = gray(m_prev + 15);
                3:       gv = gray(m_prev);
                default: gv = 4'($urandom);
            endcase
            apply(kind != 0, gv, clr);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.g        = '0;
        bus.clr_err  = 1'b0;
        test_reset();
        test_up_count();
        test_down_count();
        test_repeat_idle();
        test_illegal_resync();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_to_binary_tracker.md
Name: gray_to_binary_tracker

Overview:
- Downstream consumer of the binary-to-Gray encoder stage. It takes a stream of Gray-coded samples and decodes each one back to binary.
- It checks that every new sample is exactly one count away from the previous one, reports the direction of the step and any wrap-around, and keeps a saturating count of illegal steps.
- Use: registered monitor on Gray-coded counters and pointers.

Parameters:
- W, 4, width of the Gray input and of the binary output.
- ERR_W, 8, width of the illegal-step error counter.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  g is sampled on a rising edge when this is 1.
- g  input  W  Gray-coded input sample.
- clr_err  input  1  synchronous clear of err_count.
- out_valid  output  1  1-cycle pulse: a decoded sample is presented.
- b  output  W  decoded binary value; holds its value between samples.
- step_ok  output  1  pulse: legal +1 or -1 step.
- step_dir  output  1  direction of the last legal step (1 = up, 0 = down); holds its value.
- wrap  output  1  pulse: legal step crossed the boundary between 2^W-1 and 0.
- repeat_hit  output  1  pulse: sample equals the previous sample.
- step_err  output  1  pulse: illegal step (binary distance not 0 and not ±1).
- err_count  output  ERR_W  saturating count of illegal steps.

Behaviour:
- Reset: the clock and reset polarity are fixed as one clock, `clk`, and a synchronous active-high reset, `rst`, sampled on the rising edge of `clk`.
  - While rst=1, all outputs are 0: out_valid, b, step_ok, step_dir, wrap, repeat_hit, step_err, err_count.
  - Internal prev register is 0; state goes to UNPRIMED.
  - Reset in the middle of a stream discards history; the next sample is treated as the first one.
- Decode:
  - bin[W-1] = g[W-1]; bin[i] = bin[i+1] XOR g[i] for i = W-2 down to 0.
  - Purely combinational internally, but all outputs are registered.
- Latency: exactly 1 clock. A sample accepted at edge k appears on the outputs right after edge k, with out_valid=1 for one cycle.
- When in_valid=0:
  - out_valid and all pulse flags (step_ok, wrap, repeat_hit, step_err) are 0.
  - b, step_dir, err_count and state hold.
- State machine:
  - UNPRIMED, on a valid sample:
    - b = bin, out_valid = 1, all pulse flags 0, step_dir unchanged.
    - prev = bin; go to TRACK.
  - TRACK, on a valid sample: compute d = (bin - prev) mod 2^W, using W-bit wrap arithmetic.
    - d = 0: repeat_hit = 1.
    - d = 1: step_ok = 1, step_dir = 1; wrap = 1 if prev = 2^W-1.
    - d = 2^W-1: step_ok = 1, step_dir = 0; wrap = 1 if prev = 0.
    - Any other d: step_err = 1; err_count increments and saturates at all-ones, never rolling over.
    - In every case prev = bin (the tracker resyncs after an error); state stays TRACK.
  - Exactly one of repeat_hit / step_ok / step_err is 1 on each out_valid in TRACK. All three are 0 on the first sample after reset.
- W=1 edge case: d=1 equals 2^W-1; it is classified as up (step_dir=1, wrap=1 when prev=1).
- clr_err:
  - err_count becomes 0 at that edge.
  - If an illegal step is accepted in the same cycle, err_count becomes 1.
  - clr_err does not affect state, prev or the other outputs.
- rst has priority over clr_err and in_valid.

Test Plan (W=4, ERR_W=8):
1. Reset, then feed Gray codes of 0..15 on consecutive cycles with in_valid=1, then Gray(0).
   - b = 0..15 then 0, each exactly one cycle after its input.
   - First sample: all flags 0. Samples 1..15: step_ok=1, step_dir=1.
   - Final 15→0 step: step_ok=1, wrap=1.
   - err_count stays 0.
2. Feed the down sequence Gray(2), Gray(1), Gray(0), Gray(15).
   - step_dir=0 from the second sample on; wrap=1 only on 0→15.
3. Feed Gray(5), Gray(5) with an idle cycle between them.
   - During the idle cycle: out_valid=0, b holds 5.
   - Second Gray(5): repeat_hit=1, step_ok=0, step_err=0.
4. Feed Gray(0) then 4'b0010 (binary 3).
   - step_err=1, err_count=1.
   - Then feed Gray(4): step_ok=1, step_dir=1 (resynced to prev = 3).
5. Force 300 illegal steps.
   - err_count saturates at 255.
   - Pulse clr_err together with an illegal step: err_count=1.
   - Pulse clr_err alone: err_count=0.
6. Run the up sequence mid-stream and assert rst for one cycle.
   - All outputs are 0 after the reset edge.
   - The next valid sample produces no flags and err_count=0.
